// File: rtl/weight_buffer_pkg.sv
// Shared parameters and types for the weight buffer.
// Holds the default tile geometry shared with the SDRAM weight loader, the
// fill-FSM state encoding and a counter-width helper.
package weight_buffer_pkg;

  localparam int TM_DEF          = 8;   // output channels per tile
  localparam int TN_DEF          = 4;   // input channels per tile
  localparam int KERNEL_SIZE_DEF = 9;   // 3x3 kernel
  localparam int WGHT_W_DEF      = 16;  // weight word width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } wb_state_e;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_buffer_ram_sdp.sv
// wght_ram_sdp: simple dual-port weight RAM, DATA_W x DEPTH.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write port (written at the sampling edge)
//   raddr_i/rdata_o        registered read port, one cycle latency
// The caller keeps both addresses below DEPTH.
module wght_ram_sdp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 36,
  parameter int AW     = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_buffer.sv
// weight_buffer: double-buffered weight store fed by the SDRAM weight loader.
// A start pulse arms a fill of the back bank; the next TM*DEPTH valid read
// words land channel by channel (k fastest). Once full, a swap from the PE
// array exchanges the banks. The PE array reads all TM channels of the front
// bank in parallel at w_addr_i.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          arm a tile fill (pulse)
//   rd_data_i/rd_valid_i   loader read-data stream
//   swap_i           PE array releases the front bank
//   w_addr_i         front-bank read address
//   w_out_o          front-bank weights, channel c at [c*DATA_W +: DATA_W]
//   fill_done_o, front_valid_o, busy_o, err_overflow_o   status
module weight_buffer
  import weight_buffer_pkg::*;
#(
  parameter  int TM          = TM_DEF,
  parameter  int TN          = TN_DEF,
  parameter  int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter  int DATA_W      = WGHT_W_DEF,
  localparam int DEPTH       = KERNEL_SIZE * TN,
  localparam int AW          = cnt_w(DEPTH),
  localparam int CW          = cnt_w(TM)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DATA_W-1:0]    rd_data_i,
  input  logic                 rd_valid_i,
  input  logic                 swap_i,
  input  logic [AW-1:0]        w_addr_i,
  output logic [TM*DATA_W-1:0] w_out_o,
  output logic                 fill_done_o,
  output logic                 front_valid_o,
  output logic                 busy_o,
  output logic                 err_overflow_o
);

  wb_state_e         state_q;
  logic [AW-1:0]     k_q;
  logic [CW-1:0]     ch_q;
  logic              back_sel_q;
  logic              front_valid_q;
  logic              err_q;
  logic              front_rd_q;   // bank the in-flight read was taken from
  logic              addr_ok_q;    // in-flight read address was in range

  logic              accept;
  logic              addr_ok_d;
  logic [AW-1:0]     rd_addr;
  logic [1:0][TM-1:0][DATA_W-1:0] rdata;

  assign accept    = (state_q == S_FILL) && rd_valid_i;
  assign addr_ok_d = {1'b0, w_addr_i} < (AW+1)'(DEPTH);
  // Keep out-of-range addresses off the RAM; the result is masked anyway.
  assign rd_addr   = addr_ok_d ? w_addr_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      ch_q          <= '0;
      back_sel_q    <= 1'b0;
      front_valid_q <= 1'b0;
      err_q         <= 1'b0;
      front_rd_q    <= 1'b1;
      addr_ok_q     <= 1'b0;
    end else begin
      // Capture the read-side select with the RAM read so a swap only
      // affects reads issued after it.
      front_rd_q <= ~back_sel_q;
      addr_ok_q  <= addr_ok_d;
      if (rd_valid_i && (state_q != S_FILL)) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_FILL;
            k_q     <= '0;
            ch_q    <= '0;
          end
        end
        S_FILL: begin
          if (rd_valid_i) begin
            if (k_q == AW'(DEPTH-1)) begin
              k_q <= '0;
              if (ch_q == CW'(TM-1)) begin
                ch_q    <= '0;
                state_q <= S_FULL;
              end else begin
                ch_q <= ch_q + CW'(1);
              end
            end else begin
              k_q <= k_q + AW'(1);
            end
          end
        end
        S_FULL: begin
          if (swap_i) begin
            back_sel_q    <= ~back_sel_q;
            front_valid_q <= 1'b1;
            if (start_i) begin
              state_q <= S_FILL;
              k_q     <= '0;
              ch_q    <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar c = 0; c < TM; c++) begin : g_ch
      wght_ram_sdp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (clk_i),
        .we_i    (accept && (ch_q == CW'(c)) && (back_sel_q == 1'(b))),
        .waddr_i (k_q),
        .wdata_i (rd_data_i),
        .raddr_i (rd_addr),
        .rdata_o (rdata[b][c])
      );
    end
  end

  for (genvar c = 0; c < TM; c++) begin : g_out
    assign w_out_o[c*DATA_W +: DATA_W] = addr_ok_q ? rdata[front_rd_q][c] : '0;
  end

  assign fill_done_o    = (state_q == S_FULL);
  assign busy_o         = (state_q == S_FILL);
  assign front_valid_o  = front_valid_q;
  assign err_overflow_o = err_q;

endmodule

// File: tb/tb_weight_buffer.sv
// Directed self-checking bench for weight_buffer (TM=8, DEPTH=36, DATA_W=16).
// Word i of a tile carries base + ch*100 + k with ch=i/36, k=i%36.
module tb_weight_buffer;

  localparam int TM = 8;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NW = 288;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DW-1:0]     rd_data = '0;
  logic              rd_valid = 1'b0;
  logic              swap = 1'b0;
  logic [AW-1:0]     w_addr = '0;
  logic [TM*DW-1:0]  w_out;
  logic              fill_done, front_valid, busy, err_overflow;

  int tests = 0;
  int fails = 0;

  weight_buffer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .rd_data_i      (rd_data),
    .rd_valid_i     (rd_valid),
    .swap_i         (swap),
    .w_addr_i       (w_addr),
    .w_out_o        (w_out),
    .fill_done_o    (fill_done),
    .front_valid_o  (front_valid),
    .busy_o         (busy),
    .err_overflow_o (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] val(input int i, input int base);
    return DW'(base + (i / 36) * 100 + (i % 36));
  endfunction

  function automatic logic [TM*DW-1:0] exp_vec(input int base, input int addr);
    logic [TM*DW-1:0] v;
    v = '0;
    for (int c = 0; c < TM; c++) v[c*DW +: DW] = DW'(base + c * 100 + addr);
    return v;
  endfunction

  task automatic feed(input int first, input int n, input int base);
    for (int i = first; i < first + n; i++) begin
      rd_data  = val(i, base);
      rd_valid = 1'b1;
      tick();
    end
    rd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic rd(input int addr);
    w_addr = AW'(addr);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL reset_fill_done got %b exp 0", fill_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (front_valid !== 1'b0) begin fails++; $display("FAIL reset_front_valid got %b exp 0", front_valid); end
    tests++; if (err_overflow !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err_overflow); end
    tests++; if (w_out !== '0) begin fails++; $display("FAIL reset_w_out got %h exp 0", w_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_fill();
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL fill_busy got %b exp 1", busy); end
    feed(0, NW, 0);
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL fill_done got %b exp 1", fill_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fill_busy_end got %b exp 0", busy); end
    pulse_swap();
    tests++; if (front_valid !== 1'b1) begin fails++; $display("FAIL fill_front_valid got %b exp 1", front_valid); end
    tests++; if (fill_done !== 1'b0) begin fails++; $display("FAIL fill_done_fall got %b exp 0", fill_done); end
    rd(5);
    tests++; if (w_out[3*DW +: DW] !== 16'd305) begin fails++; $display("FAIL fill_ch3_a5 got %0d exp 305", w_out[3*DW +: DW]); end
    tests++; if (w_out !== exp_vec(0, 5)) begin fails++; $display("FAIL fill_vec_a5 got %h exp %h", w_out, exp_vec(0, 5)); end
    rd(35);
    tests++; if (w_out !== exp_vec(0, 35)) begin fails++; $display("FAIL fill_vec_a35 got %h exp %h", w_out, exp_vec(0, 35)); end
    rd(36);
    tests++; if (w_out !== '0) begin fails++; $display("FAIL fill_oob_a36 got %h exp 0", w_out); end
  endtask

  task automatic test_gapped();
    logic early;
    early = 1'b0;
    pulse_start();
    for (int i = 0; i < NW; i++) begin
      rd_data  = val(i, 2000);
      rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      if (i < NW - 1) begin
        if (fill_done) early = 1'b1;
        tick();
        if (fill_done) early = 1'b1;
        tick();
        if (fill_done) early = 1'b1;
      end
    end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL gap_early_done got %b exp 0", early); end
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL gap_done got %b exp 1", fill_done); end
    // Front bank (tile A) must be untouched by the back-bank fill.
    rd(9);
    tests++; if (w_out !== exp_vec(0, 9)) begin fails++; $display("FAIL gap_front_a9 got %h exp %h", w_out, exp_vec(0, 9)); end
  endtask

  task automatic test_pingpong();
    pulse_swap();
    tests++; if (front_valid !== 1'b1) begin fails++; $display("FAIL pp_front_valid got %b exp 1", front_valid); end
    rd(10);
    tests++; if (w_out !== exp_vec(2000, 10)) begin fails++; $display("FAIL pp_b_a10 got %h exp %h", w_out, exp_vec(2000, 10)); end
    pulse_start();
    feed(0, 150, 4000);
    rd(7);
    tests++; if (w_out !== exp_vec(2000, 7)) begin fails++; $display("FAIL pp_b_during_fill got %h exp %h", w_out, exp_vec(2000, 7)); end
    feed(150, NW - 150, 4000);
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL pp_c_done got %b exp 1", fill_done); end
    pulse_swap();
    rd(3);
    tests++; if (w_out !== exp_vec(4000, 3)) begin fails++; $display("FAIL pp_c_a3 got %h exp %h", w_out, exp_vec(4000, 3)); end
    pulse_swap();
    tests++; if (busy !== 1'b0 || fill_done !== 1'b0) begin fails++; $display("FAIL pp_idle_swap got busy=%b done=%b exp 0 0", busy, fill_done); end
    rd(3);
    tests++; if (w_out !== exp_vec(4000, 3)) begin fails++; $display("FAIL pp_swap_ignored got %h exp %h", w_out, exp_vec(4000, 3)); end
  endtask

  task automatic test_overflow();
    pulse_start();
    feed(0, NW, 6000);
    rd_data  = 16'h7777;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    tests++; if (err_overflow !== 1'b1) begin fails++; $display("FAIL ovf_full_err got %b exp 1", err_overflow); end
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL ovf_full_state got %b exp 1", fill_done); end
    pulse_swap();
    rd(0);
    tests++; if (w_out !== exp_vec(6000, 0)) begin fails++; $display("FAIL ovf_d_a0 got %h exp %h", w_out, exp_vec(6000, 0)); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (err_overflow !== 1'b0) begin fails++; $display("FAIL ovf_err_clear got %b exp 0", err_overflow); end
    rd_data  = 16'h5555;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    tests++; if (err_overflow !== 1'b1) begin fails++; $display("FAIL ovf_idle_err got %b exp 1", err_overflow); end
    tests++; if (busy !== 1'b0 || fill_done !== 1'b0) begin fails++; $display("FAIL ovf_idle_state got busy=%b done=%b exp 0 0", busy, fill_done); end
    // Contents survive reset; after reset the front is the bank holding D.
    rd(0);
    tests++; if (w_out !== exp_vec(6000, 0)) begin fails++; $display("FAIL ovf_ram_kept got %h exp %h", w_out, exp_vec(6000, 0)); end
  endtask

  task automatic test_swap_start();
    pulse_start();
    feed(0, NW, 8000);
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL ss_e_done got %b exp 1", fill_done); end
    swap  = 1'b1;
    start = 1'b1;
    tick();
    swap  = 1'b0;
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ss_busy got %b exp 1", busy); end
    tests++; if (front_valid !== 1'b1 || fill_done !== 1'b0) begin fails++; $display("FAIL ss_status got fv=%b done=%b exp 1 0", front_valid, fill_done); end
    rd(20);
    tests++; if (w_out !== exp_vec(8000, 20)) begin fails++; $display("FAIL ss_e_a20 got %h exp %h", w_out, exp_vec(8000, 20)); end
    feed(0, NW, 10000);
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL ss_f_done got %b exp 1", fill_done); end
    pulse_swap();
    rd(20);
    tests++; if (w_out !== exp_vec(10000, 20)) begin fails++; $display("FAIL ss_f_a20 got %h exp %h", w_out, exp_vec(10000, 20)); end
  endtask

  task automatic test_reset_midfill();
    pulse_start();
    feed(0, 100, 12000);
    rst = 1'b1;
    tick();
    tests++; if (busy !== 1'b0 || fill_done !== 1'b0) begin fails++; $display("FAIL rm_state got busy=%b done=%b exp 0 0", busy, fill_done); end
    tests++; if (front_valid !== 1'b0) begin fails++; $display("FAIL rm_front_valid got %b exp 0", front_valid); end
    tests++; if (err_overflow !== 1'b0) begin fails++; $display("FAIL rm_err got %b exp 0", err_overflow); end
    tests++; if (w_out !== '0) begin fails++; $display("FAIL rm_w_out got %h exp 0", w_out); end
    rst = 1'b0;
    tick();
    pulse_start();
    feed(0, NW, 20000);
    tests++; if (fill_done !== 1'b1) begin fails++; $display("FAIL rm_refill_done got %b exp 1", fill_done); end
    pulse_swap();
    rd(1);
    tests++; if (w_out !== exp_vec(20000, 1)) begin fails++; $display("FAIL rm_refill_a1 got %h exp %h", w_out, exp_vec(20000, 1)); end
    tests++; if (front_valid !== 1'b1) begin fails++; $display("FAIL rm_front_valid_end got %b exp 1", front_valid); end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_gapped();
    test_pingpong();
    test_overflow();
    test_swap_start();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_buffer.md
# weight_buffer

Double-buffered on-chip weight store directly downstream of the SDRAM weight loader. It captures the read-data stream that the loader's read requests produce, and steers each word into one of TM per-output-channel RAMs in the back bank. When the back bank is full and the convolution PE array releases the front bank, the two banks swap. The PE array reads all TM channels of the front bank in parallel, one kernel/input-channel position per address.

## Interface
- TM, default 8: output channels per tile; number of channel RAMs per bank.
- TN, default 4: input channels per tile.
- KERNEL_SIZE, default 9: weights per kernel (3x3).
- DATA_W, default 16: weight word width.
- DEPTH, derived as KERNEL_SIZE*TN (36): words per channel RAM.
- AW, derived as clog2(DEPTH): address width.

Ports:
- clk  in  1: single clock; all logic on posedge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: one-cycle pulse that arms a tile fill of the back bank. It is issued together with the loader's enable.
- rd_data  in  DATA_W: SDRAM read data.
- rd_valid  in  1: rd_data holds a valid weight word this cycle.
- swap  in  1: the PE array is finished with the front bank.
- w_addr  in  AW: front-bank read address.
- w_out  out  TM*DATA_W: front-bank weights. Channel c occupies bits [c*DATA_W +: DATA_W].
- fill_done  out  1: the back bank holds a complete tile.
- front_valid  out  1: the front bank holds a valid tile.
- busy  out  1: a fill is in progress.
- err_overflow  out  1: sticky; set when a word arrives while no fill is in progress.

## Operation
- **Word order:** matches the loader's request order. Channel 0 words k=0..DEPTH-1 arrive first, then channel 1, and so on up to channel TM-1. Total TM*DEPTH words (288) per tile.
- **State machine:** IDLE, FILL, FULL.
  - IDLE: on start, go to FILL and clear the counters k and ch.
  - FILL: on each rd_valid, write rd_data to back-bank RAM[ch] at address k, then advance k. When k wraps from DEPTH-1 to 0, increment ch. The word with ch=TM-1 and k=DEPTH-1 sends the state to FULL.
  - FULL: on swap, toggle back_sel, set front_valid=1, and return to IDLE. If swap and start occur in the same cycle, swap and go straight to FILL with cleared counters.
- **Ignored inputs:**
  - start in FILL or FULL is ignored, except start coincident with swap in FULL.
  - swap in IDLE or FILL is ignored; no bank change.
- **Overflow:** rd_valid in IDLE or FULL sets err_overflow. That word is discarded and no RAM is written.
- **Status outputs:** fill_done = (state==FULL); busy = (state==FILL).
- **Read path:** the front bank is the bank not selected by back_sel. w_out is registered from all TM front RAMs at address w_addr. If w_addr >= DEPTH, w_out is 0.
- **Bank contents:** never cleared. Only front_valid qualifies them.
- **Reset values:** state IDLE, k=0, ch=0, back_sel=0, fill_done=0, front_valid=0, busy=0, err_overflow=0, w_out=0.
- **Reset mid-fill:** the fill is abandoned and partial data is left in the RAM. front_valid drops to 0.

## Timing
- **Write:** rd_valid sampled at edge t writes the RAM at edge t. Valid words may arrive back-to-back or with arbitrary gaps.
- **fill_done:** rises in the cycle after the edge that samples the last word.
- **Start to first write:** start at edge t means the first word can be accepted at edge t+1 or later. A word coincident with start is an overflow.
- **Read latency:** 1 cycle. w_addr sampled at edge t gives w_out valid after edge t+1.
- **Swap:** swap sampled at edge t changes the bank selection at edge t. A w_addr sampled at edge t+1 returns new-front data after edge t+2. fill_done falls after edge t.
- **Sustained rate:** one new tile every max(TM*DEPTH+1, PE compute) cycles.

## Structure
- **Shared defines header:** KERNEL_SIZE, Tn, Tm, WGHT_W, and WGHT_CNTR_W live in the codebase's shared header. The loader and this block both use them, so their defaults come from those macros.
- **Sub-module wght_ram_sdp:** simple dual-port RAM, one write port and one registered read port, DATA_W x DEPTH. Instantiated 2*TM times with generate loops.
- **Top-level logic:** the FSM, counters, write decode, and output mux live in the top.

## Test plan
- **Full fill and read:** start, then 288 back-to-back words with value = ch*100+k, then swap. front_valid=1; w_addr=5 gives w_out channel 3 = 305 after 1 cycle; w_addr=36 gives w_out=0.
- **Gapped stream:** rd_valid every 3rd cycle. fill_done rises exactly 1 cycle after the 288th valid word, never earlier.
- **Ping-pong:** fill tile A, swap, fill tile B while reading A (A data unchanged), swap. Reads now return B. A third swap without a fill is ignored.
- **Overflow:** 289th word, and a word in IDLE. err_overflow=1, RAM contents unchanged, state remains FULL/IDLE.
- **Simultaneous swap and start in FULL:** banks swap, busy=1 the next cycle, and the next 288 words fill the new back bank.
- **Reset mid-fill:** reset after 100 words. All outputs return to their reset values, and a subsequent full fill completes normally.
